multi_game_timer: RTL
=====================

// Module: multi_game_timer
// PURPOSE
//  NUM_TIMERS independent millisecond timers sharing one ms prescaler. Each channel counts down or up,
//  one-shot or auto-reload, with start/pause/load control and expiry flags. Drives game round clocks,
//  reaction windows and per-player countdowns from the game FSM; values feed the 7-seg display path.
// PARAMETERS
//  NUM_TIMERS   4      number of independent channels (1..16)
//  MAX_MS       2047   largest representable ms value; VW = $clog2(MAX_MS+1)
//  CLKS_PER_MS  50000  clk cycles per ms tick (50 MHz); >= 2
// PORTS
//  clk          in   1              system clock
//  reset        in   1              synchronous, active-high reset
//  start_value  in   NUM_TIMERS*VW  per-channel load value, ch i at [i*VW +: VW]
//  load         in   NUM_TIMERS     per-channel load strobe
//  start        in   NUM_TIMERS     per-channel start/resume strobe
//  pause        in   NUM_TIMERS     per-channel pause strobe
//  count_up     in   NUM_TIMERS     mode sampled at load: 1 = count 0->target, 0 = count target->0
//  auto_reload  in   NUM_TIMERS     mode sampled at load: 1 = reload on expiry and keep running
//  timer_value  out  NUM_TIMERS*VW  current count per channel
//  running      out  NUM_TIMERS     1 while channel in RUN
//  expired      out  NUM_TIMERS     1-cycle pulse on each expiry
//  done         out  NUM_TIMERS     sticky: set on one-shot expiry, cleared by load/reset
// BEHAVIOUR
//  Reset: prescaler=0; every channel state=IDLE, value=0, target=0, modes=0; running/expired/done=0.
//  Prescaler: free-runs from reset 0..CLKS_PER_MS-1, wraps to 0; ms_tick=1 for the cycle cnt==CLKS_PER_MS-1.
//   Ticks every CLKS_PER_MS cycles regardless of channel state; first ms after start may be short (<=1 ms).
//  Per-channel state: IDLE, RUN, PAUSE, EXPIRED (2 bits). Priority per cycle: reset > load > pause > start > tick.
//  load: target<=min(start_value,MAX_MS); value<=count_up?0:target; latch count_up/auto_reload;
//   done<=0; state<=IDLE, or RUN if start also high that cycle (load-and-go). pause ignored on load cycle.
//  start: IDLE/PAUSE -> RUN; ignored in RUN, EXPIRED and when pause high same cycle.
//  pause: RUN -> PAUSE; value held; ignored in other states.
//  Tick in RUN (registered; effects visible the cycle after ms_tick):
//   down: if value<=1 -> expiry, value<=0; else value<=value-1.
//   up:   if value+1>=target -> expiry, value<=target; else value<=value+1. target==0 -> expiry on first tick.
//   down with value==0 at start -> expiry on first tick, value stays 0.
//  Expiry: expired pulses 1 cycle (same edge value updates). auto_reload=1: value<=count_up?0:target,
//   stay RUN, done unchanged. auto_reload=0: state<=EXPIRED, done<=1, value frozen.
//  EXPIRED: only load or reset leave it. Ticks in IDLE/PAUSE/EXPIRED change nothing.
//  Value arithmetic VW bits, never wraps: down floors at 0, up ceilings at target (<=MAX_MS).
//  Channels fully independent; simultaneous events on different channels all honoured same cycle.
//  Reset mid-count: all channels to reset values next edge, prescaler restarts at 0, no expired pulse.
//  running = (state==RUN), registered/decoded from state; outputs never X after first reset edge.
// STRUCTURE
//  Shared package/include timer_pkg: state encodings (ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_EXPIRED=3),
//   VW width function, channel slice macro.
//  Sub-module ms_tick_gen #(CLKS_PER_MS) (clk, reset, tick): the shared prescaler.
//  Channel logic in a generate loop over NUM_TIMERS; no per-channel prescaler.
// TESTING  (bench uses CLKS_PER_MS=4, MAX_MS=15, NUM_TIMERS=2)
//  1 Down one-shot: load ch0=3,start -> value 3,2,1,0 on successive ticks; expired pulse with 0; done=1, running=0.
//  2 Up auto-reload: load ch1=2,count_up,auto_reload,start -> 0,1,2->0 (expired pulse),1,2->0 ...; done stays 0.
//  3 Pause/resume: ch0=5 running, pause after 2 ticks -> value 3 held 3 ticks; start -> resumes 2,1,0.
//  4 Priority: load+start same cycle -> RUN from start_value; pause+start -> stays RUN/PAUSE unchanged;
//    start while EXPIRED -> ignored; load 20 -> clamped to 15.
//  5 Edges: down load 0 + start -> expired on first tick; up target 0 -> expired on first tick; no wrap past 0/15.
//  6 Reset mid-run (both channels active) -> next cycle all values 0, states IDLE, flags 0, tick phase restarts.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel game timer.
//   timer_state_t : per-channel state encoding
//   value_width   : bits needed to hold 0..max_ms
//   TIMER_SLICE   : part-select of channel idx in a flat bus of w-bit fields
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } timer_state_t;

    function automatic int unsigned value_width(input int unsigned max_ms);
        return (max_ms < 1) ? 1 : $clog2(max_ms + 1);
    endfunction

endpackage

`define TIMER_SLICE(idx, w) (idx)*(w) +: (w)

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler shared by all timer channels.
//   clk   : system clock
//   reset : synchronous active-high reset, restarts the count at 0
//   tick  : high for the one cycle in which the count is CLKS_PER_MS-1
module ms_tick_gen #(
    parameter int unsigned CLKS_PER_MS = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned CW = $clog2(CLKS_PER_MS);

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(CLKS_PER_MS - 1));

    // Wrap at CLKS_PER_MS-1 regardless of channel activity
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/multi_game_timer.sv
// NUM_TIMERS independent millisecond up/down timers sharing one prescaler.
//   start_value : per-channel load value, channel i at [i*VW +: VW]
//   load/start/pause : per-channel strobes (priority load > pause > start)
//   count_up/auto_reload : per-channel modes, latched on load
//   timer_value : current count per channel
//   running     : channel is in RUN
//   expired     : one-cycle pulse on each expiry
//   done        : sticky one-shot expiry flag, cleared by load
module multi_game_timer
    import timer_pkg::*;
#(
    parameter int unsigned NUM_TIMERS  = 4,
    parameter int unsigned MAX_MS      = 2047,
    parameter int unsigned CLKS_PER_MS = 50000,
    localparam int unsigned VW         = value_width(MAX_MS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_TIMERS*VW-1:0] start_value,
    input  logic [NUM_TIMERS-1:0]    load,
    input  logic [NUM_TIMERS-1:0]    start,
    input  logic [NUM_TIMERS-1:0]    pause,
    input  logic [NUM_TIMERS-1:0]    count_up,
    input  logic [NUM_TIMERS-1:0]    auto_reload,
    output logic [NUM_TIMERS*VW-1:0] timer_value,
    output logic [NUM_TIMERS-1:0]    running,
    output logic [NUM_TIMERS-1:0]    expired,
    output logic [NUM_TIMERS-1:0]    done
);

    logic ms_tick;

    ms_tick_gen #(
        .CLKS_PER_MS (CLKS_PER_MS)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (ms_tick)
    );

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_ch
        timer_state_t  state;
        logic [VW-1:0] value;
        logic [VW-1:0] target;
        logic          up_mode;
        logic          ar_mode;
        logic          exp_q;
        logic          done_q;
        logic [VW-1:0] sv_c;
        logic [VW-1:0] tgt_c;
        logic [VW:0]   inc_c;

        assign sv_c  = start_value[`TIMER_SLICE(i, VW)];
        assign tgt_c = (32'(sv_c) > MAX_MS) ? VW'(MAX_MS) : sv_c;
        // One extra bit so value+1 cannot wrap before the target compare
        assign inc_c = {1'b0, value} + (VW + 1)'(1);

        always_ff @(posedge clk) begin
            if (reset) begin
                state   <= ST_IDLE;
                value   <= '0;
                target  <= '0;
                up_mode <= 1'b0;
                ar_mode <= 1'b0;
                exp_q   <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                exp_q <= 1'b0;
                if (load[i]) begin
                    target  <= tgt_c;
                    value   <= count_up[i] ? '0 : tgt_c;
                    up_mode <= count_up[i];
                    ar_mode <= auto_reload[i];
                    done_q  <= 1'b0;
                    state   <= start[i] ? ST_RUN : ST_IDLE;
                end else if (pause[i]) begin
                    if (state == ST_RUN) begin
                        state <= ST_PAUSE;
                    end
                end else if (start[i]) begin
                    if (state == ST_IDLE || state == ST_PAUSE) begin
                        state <= ST_RUN;
                    end
                end else if (ms_tick && state == ST_RUN) begin
                    if ((up_mode && inc_c >= {1'b0, target}) ||
                        (!up_mode && value <= VW'(1))) begin
                        exp_q <= 1'b1;
                        if (ar_mode) begin
                            value <= up_mode ? '0 : target;
                        end else begin
                            value  <= up_mode ? target : '0;
                            state  <= ST_EXPIRED;
                            done_q <= 1'b1;
                        end
                    end else if (up_mode) begin
                        value <= inc_c[VW-1:0];
                    end else begin
                        value <= value - VW'(1);
                    end
                end
            end
        end

        assign timer_value[`TIMER_SLICE(i, VW)] = value;
        assign running[i] = (state == ST_RUN);
        assign expired[i] = exp_q;
        assign done[i]    = done_q;
    end

endmodule
